// File: rtl/wave_analyzer.sv
// wave_analyzer: on a start request, measures one full period of an 8-bit
// sample stream between two hysteresis-qualified rising mid-level crossings.
// Also captures min, max and peak-to-peak over that period, then pulses done.
module wave_analyzer #(
  parameter logic [7:0] MID     = 8'd127,
  parameter logic [7:0] HYST    = 8'd8,
  parameter int         PW      = 12,
  parameter int         TIMEOUT = 2047
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sample_valid,
  input  logic [7:0]    sample,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [PW-1:0] period,
  output logic [7:0]    vmin,
  output logic [7:0]    vmax,
  output logic [7:0]    amp
);

  localparam logic [7:0]    LO_LVL = MID - HYST;
  localparam logic [7:0]    HI_LVL = MID + HYST;
  localparam logic [PW-1:0] TO_CNT = PW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          arm;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_inc;
  logic [7:0]    wmin, wmax;
  logic [7:0]    new_min, new_max;
  logic [7:0]    res_min, res_max;
  logic          is_low, is_high, crossing;
  logic          fin, fin_to;

  // Sample classification and working-value helpers.
  always_comb begin
    is_low   = (sample <= LO_LVL);
    is_high  = (sample >= HI_LVL);
    crossing = sample_valid && arm && is_high;
    new_min  = (sample < wmin) ? sample : wmin;
    new_max  = (sample > wmax) ? sample : wmax;
    // The counter saturates at the timeout value instead of wrapping.
    cnt_inc  = (cnt == TO_CNT) ? cnt : cnt + 1'b1;
  end

  // Next-state logic, end-of-measurement detection and status outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    fin     = 1'b0;
    fin_to  = 1'b0;
    res_min = wmin;
    res_max = wmax;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        if (sample_valid) begin
          if (crossing) begin
            state_d = S_MEASURE;
          end else if (cnt_inc == TO_CNT) begin
            state_d = S_DONE;
            fin     = 1'b1;
            fin_to  = 1'b1;
          end
        end
      end
      S_MEASURE: begin
        if (sample_valid) begin
          // The terminating sample is part of the measured period.
          res_min = new_min;
          res_max = new_max;
          if (crossing) begin
            state_d = S_DONE;
            fin     = 1'b1;
          end else if (cnt_inc == TO_CNT) begin
            state_d = S_DONE;
            fin     = 1'b1;
            fin_to  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Arm flag, sample counter, working min/max and latched results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arm     <= 1'b0;
      cnt     <= '0;
      wmin    <= '0;
      wmax    <= '0;
      period  <= '0;
      vmin    <= '0;
      vmax    <= '0;
      amp     <= '0;
      timeout <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        arm  <= 1'b0;
        cnt  <= '0;
        wmin <= '0;
        wmax <= '0;
      end
      if ((state_q == S_ARM || state_q == S_MEASURE) && sample_valid) begin
        // Low samples arm, a crossing disarms, in-band samples leave it alone.
        if (crossing)    arm <= 1'b0;
        else if (is_low) arm <= 1'b1;
        if (state_q == S_ARM && crossing) begin
          cnt  <= PW'(1);
          wmin <= sample;
          wmax <= sample;
        end else begin
          cnt <= cnt_inc;
          if (state_q == S_MEASURE) begin
            wmin <= new_min;
            wmax <= new_max;
          end
        end
      end
      if (fin) begin
        period  <= fin_to ? '0 : cnt;
        vmin    <= res_min;
        vmax    <= res_max;
        amp     <= res_max - res_min;
        timeout <= fin_to;
      end
    end
  end

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed testbench for wave_analyzer: triangle, square, half-rate, timeout,
// ignored start requests, back-to-back measurements and mid-measurement reset.
module tb_wave_analyzer;

  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sample_valid;
  logic [7:0]    sample;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [PW-1:0] period;
  logic [7:0]    vmin;
  logic [7:0]    vmax;
  logic [7:0]    amp;

  int tests = 0;
  int fails = 0;

  wave_analyzer #(.PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .period       (period),
    .vmin         (vmin),
    .vmax         (vmax),
    .amp          (amp)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then observe just after the rising edge.
  task automatic step(input logic st, input logic v, input logic [7:0] s);
    start        = st;
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  // kind 0: triangle, 1: square, 2: constant 127, 3: alternating 125/130.
  function automatic logic [7:0] wave(input int kind, input int k);
    int m;
    m = k % 256;
    case (kind)
      0:       wave = (m < 128) ? 8'(2 * m) : 8'(2 * (255 - m));
      1:       wave = (m < 128) ? 8'd255 : 8'd0;
      2:       wave = 8'd127;
      default: wave = (k % 2 == 1) ? 8'd130 : 8'd125;
    endcase
  endfunction

  // Issue start, then stream samples until done (bounded). done_at is the
  // stream step on which done was observed, or -1 if it never came.
  task automatic run_stream(input int kind, input bit half, input bit poke,
                            output int done_at, output logic busy0);
    int k;
    logic v;
    step(1'b1, 1'b0, 8'h00);
    busy0   = busy;
    done_at = -1;
    for (int n = 1; n <= 6000; n++) begin
      v = !half || (n % 2 == 1);
      k = half ? (n - 1) / 2 : n - 1;
      step(poke && (n % 5 == 0), v, wave(kind, k));
      if (done) begin
        done_at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    tests++; if (period !== 12'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", period); end
    tests++; if ({vmin, vmax, amp} !== 24'd0) begin fails++; $display("FAIL reset_values: got %h expected 000000", {vmin, vmax, amp}); end
  endtask

  task automatic test_triangle();
    int   at;
    logic b0;
    run_stream(0, 1'b0, 1'b0, at, b0);
    tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL tri_busy_rise: got %b expected 1", b0); end
    tests++; if (at != 325) begin fails++; $display("FAIL tri_done_step: got %0d expected 325", at); end
    tests++; if (period !== 12'd256) begin fails++; $display("FAIL tri_period: got %0d expected 256", period); end
    tests++; if (vmin !== 8'd0) begin fails++; $display("FAIL tri_vmin: got %0d expected 0", vmin); end
    tests++; if (vmax !== 8'd254) begin fails++; $display("FAIL tri_vmax: got %0d expected 254", vmax); end
    tests++; if (amp !== 8'd254) begin fails++; $display("FAIL tri_amp: got %0d expected 254", amp); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL tri_timeout: got %b expected 0", timeout); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL tri_busy_in_done: got %b expected 1", busy); end
    step(1'b0, 1'b1, 8'd0);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL tri_done_pulse: got %b expected 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tri_busy_fall: got %b expected 0", busy); end
    step(1'b0, 1'b1, 8'd200);
    tests++; if (period !== 12'd256 || amp !== 8'd254) begin fails++; $display("FAIL tri_hold: got period %0d amp %0d expected 256 254", period, amp); end
  endtask

  task automatic test_square();
    int   at;
    logic b0;
    run_stream(1, 1'b0, 1'b0, at, b0);
    tests++; if (at != 513) begin fails++; $display("FAIL sq_done_step: got %0d expected 513", at); end
    tests++; if (period !== 12'd256) begin fails++; $display("FAIL sq_period: got %0d expected 256", period); end
    tests++; if ({vmin, vmax, amp} !== {8'd0, 8'd255, 8'd255}) begin fails++; $display("FAIL sq_values: got %0d %0d %0d expected 0 255 255", vmin, vmax, amp); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL sq_timeout: got %b expected 0", timeout); end
    step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_half_rate();
    int   at;
    logic b0;
    run_stream(0, 1'b1, 1'b0, at, b0);
    tests++; if (at != 649) begin fails++; $display("FAIL half_done_step: got %0d expected 649", at); end
    tests++; if (period !== 12'd256) begin fails++; $display("FAIL half_period: got %0d expected 256", period); end
    tests++; if ({vmin, vmax, amp} !== {8'd0, 8'd254, 8'd254}) begin fails++; $display("FAIL half_values: got %0d %0d %0d expected 0 254 254", vmin, vmax, amp); end
    step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_timeout(input int kind);
    int   at;
    logic b0;
    run_stream(kind, 1'b0, 1'b0, at, b0);
    tests++; if (at != 2047) begin fails++; $display("FAIL to%0d_done_step: got %0d expected 2047", kind, at); end
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL to%0d_flag: got %b expected 1", kind, timeout); end
    tests++; if (period !== 12'd0) begin fails++; $display("FAIL to%0d_period: got %0d expected 0", kind, period); end
    tests++; if ({vmin, vmax, amp} !== 24'd0) begin fails++; $display("FAIL to%0d_values: got %0d %0d %0d expected 0 0 0", kind, vmin, vmax, amp); end
    step(1'b0, 1'b0, 8'd0);
    tests++; if (timeout !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL to%0d_hold: got timeout %b done %b expected 1 0", kind, timeout, done); end
  endtask

  task automatic test_start_ignored();
    int   at;
    int   extra;
    logic b0;
    run_stream(0, 1'b0, 1'b1, at, b0);
    tests++; if (at != 325) begin fails++; $display("FAIL poke_done_step: got %0d expected 325", at); end
    tests++; if (period !== 12'd256) begin fails++; $display("FAIL poke_period: got %0d expected 256", period); end
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 1'b1, wave(0, n));
      if (done) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL poke_extra_done: got %0d expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int   at;
    logic b0;
    run_stream(1, 1'b0, 1'b0, at, b0);
    // start in the DONE cycle must be ignored.
    step(1'b1, 1'b0, 8'd0);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_start_in_done: got busy %b expected 0", busy); end
    run_stream(0, 1'b0, 1'b0, at, b0);
    tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy %b expected 1", b0); end
    tests++; if (at != 325 || period !== 12'd256) begin fails++; $display("FAIL b2b_result: got step %0d period %0d expected 325 256", at, period); end
    tests++; if (vmax !== 8'd254) begin fails++; $display("FAIL b2b_vmax: got %0d expected 254", vmax); end
    step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset_mid();
    int   at;
    int   extra;
    logic b0;
    step(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 150; k++) step(1'b0, 1'b1, wave(0, k));
    rst = 1'b0;
    step(1'b0, 1'b1, wave(0, 150));
    rst = 1'b1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rmid_status: got busy %b done %b expected 0 0", busy, done); end
    tests++; if (period !== 12'd0 || {vmin, vmax, amp} !== 24'd0) begin fails++; $display("FAIL rmid_outputs: got %0d %0d %0d %0d expected all 0", period, vmin, vmax, amp); end
    extra = 0;
    for (int k = 151; k < 551; k++) begin
      step(1'b0, 1'b1, wave(0, k));
      if (done || busy) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL rmid_no_done: got %0d busy/done cycles expected 0", extra); end
    run_stream(0, 1'b0, 1'b0, at, b0);
    tests++; if (at != 325 || period !== 12'd256) begin fails++; $display("FAIL rmid_rerun: got step %0d period %0d expected 325 256", at, period); end
    step(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample       = 8'h00;
    test_reset();
    test_triangle();
    test_square();
    test_half_rate();
    test_timeout(2);
    test_timeout(3);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
